// File: rtl/instr_cache_set_multi_pkg.sv
// Shared parameters for the instruction cache set.
// Default geometry: 64-byte blocks, 26-bit tags, 4 ways.
package instr_cache_set_multi_pkg;
    localparam int unsigned IC_B        = 64;
    localparam int unsigned IC_TAG_BITS = 26;
    localparam int unsigned IC_E        = 4;
    localparam int unsigned IC_BEAT_W   = 64;
    localparam int unsigned IC_WORD_W   = 32;
endpackage

// File: rtl/cache_lru_ctrl.sv
// Per-set age tracking and victim selection.
// Age 0 is most recent, E-1 is the victim.
module cache_lru_ctrl
    import instr_cache_set_multi_pkg::*;
#(
    parameter int unsigned E  = IC_E,
    parameter int unsigned AW = $clog2(E)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          update_i,
    input  logic [AW-1:0] way_i,
    output logic [AW-1:0] victim_o
);

    logic [AW-1:0] lru_bits [E];

    always_comb begin
        victim_o = '0;
        for (int i = 0; i < int'(E); i++) begin
            if (lru_bits[i] == AW'(E - 1)) begin
                victim_o = AW'(i);
            end
        end
    end

    // Ways younger than the touched way age by one; older ways keep their age.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < int'(E); i++) begin
                lru_bits[i] <= AW'(int'(E) - 1 - i);
            end
        end else if (update_i) begin
            for (int i = 0; i < int'(E); i++) begin
                if (AW'(i) == way_i) begin
                    lru_bits[i] <= '0;
                end else if (lru_bits[i] < lru_bits[way_i]) begin
                    lru_bits[i] <= lru_bits[i] + AW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/instr_cache_set_multi.sv
// One set of an E-way instruction cache: tag/data/valid storage,
// combinational lookup and beat-wise refill of the LRU victim.
module instr_cache_set_multi
    import instr_cache_set_multi_pkg::*;
#(
    parameter int unsigned B            = IC_B,
    parameter int unsigned num_tag_bits = IC_TAG_BITS,
    parameter int unsigned E            = IC_E
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    active_set_i,
    input  logic                    ic_repl_grant_i,
    input  logic [$clog2(B)-1:0]    block_i,
    input  logic [num_tag_bits-1:0] tag_i,
    input  logic [IC_BEAT_W-1:0]    rep_word_i,
    output logic [IC_WORD_W-1:0]    data_o,
    output logic                    cache_set_miss_o
);

    localparam int unsigned BEATS = B / 8;
    localparam int unsigned CW    = $clog2(BEATS);
    localparam int unsigned AW    = $clog2(E);
    localparam int unsigned OW    = $clog2(B);
    localparam int unsigned DW    = B * 8;
    localparam int unsigned BW    = $clog2(DW);

    logic [E-1:0]            valid_q;
    logic [num_tag_bits-1:0] tag_q  [E];
    logic [DW-1:0]           data_q [E];
    logic [CW-1:0]           cnt_q, cnt_d;

    logic          hit;
    logic [AW-1:0] hit_way;
    logic [AW-1:0] victim;
    logic [AW-1:0] upd_way;
    logic          fill_en;
    logic          last_beat;
    logic          fill_done;
    logic [BW-1:0] word_base;
    logic [BW-1:0] beat_base;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int i = 0; i < int'(E); i++) begin
            if (active_set_i && valid_q[i] && tag_q[i] == tag_i) begin
                hit     = 1'b1;
                hit_way = AW'(i);
            end
        end
    end

    // Word-aligned read: low two offset bits are dropped.
    assign word_base = {block_i[OW-1:2], 5'b00000};
    assign beat_base = {cnt_q, 6'b000000};

    assign data_o           = hit ? data_q[hit_way][word_base +: IC_WORD_W] : '0;
    assign cache_set_miss_o = ~hit;

    assign fill_en   = active_set_i & ~hit & ic_repl_grant_i;
    assign last_beat = (cnt_q == CW'(BEATS - 1));
    assign fill_done = fill_en & last_beat;
    assign upd_way   = hit ? hit_way : victim;

    always_comb begin
        cnt_d = '0;
        if (fill_en && !last_beat) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt_q   <= '0;
            valid_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (fill_done) begin
                valid_q[victim] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (fill_en) begin
            data_q[victim][beat_base +: IC_BEAT_W] <= rep_word_i;
        end
        if (fill_done) begin
            tag_q[victim] <= tag_i;
        end
    end

    cache_lru_ctrl #(
        .E  (E),
        .AW (AW)
    ) u_lru (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .update_i (hit | fill_done),
        .way_i    (upd_way),
        .victim_o (victim)
    );

endmodule

// File: tb/tb_instr_cache_set_multi.sv
// Directed bench for instr_cache_set_multi: fills, hits, ages,
// inactive-set holding, partial-fill abort and reset mid-fill.
module tb_instr_cache_set_multi;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        active_set_i;
    logic        ic_repl_grant_i;
    logic [5:0]  block_i;
    logic [25:0] tag_i;
    logic [63:0] rep_word_i;
    logic [31:0] data_o;
    logic        cache_set_miss_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] beats [8];
    logic [25:0] tags  [4];
    logic [5:0]  blks  [4];
    logic [31:0] hexp  [4];

    localparam logic [63:0] SALT = 64'h0F0F_1234_5A5A_C3C3;

    always #5 clk_i = ~clk_i;

    instr_cache_set_multi dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .active_set_i     (active_set_i),
        .ic_repl_grant_i  (ic_repl_grant_i),
        .block_i          (block_i),
        .tag_i            (tag_i),
        .rep_word_i       (rep_word_i),
        .data_o           (data_o),
        .cache_set_miss_o (cache_set_miss_o)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_lru(input string tag, input int w0, input int w1,
                             input int w2, input int w3);
        logic [7:0] obs;
        logic [7:0] exp;
        obs = {dut.u_lru.lru_bits[3], dut.u_lru.lru_bits[2],
               dut.u_lru.lru_bits[1], dut.u_lru.lru_bits[0]};
        exp = {w3[1:0], w2[1:0], w1[1:0], w0[1:0]};
        check(tag, {24'd0, obs}, {24'd0, exp});
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] word_of(input logic [63:0] salt,
                                            input logic [5:0] blk);
        logic [511:0] line;
        int base;
        for (int b = 0; b < 8; b++) line[b*64 +: 64] = beats[b] ^ salt;
        base = int'(blk[5:2]) * 32;
        return line[base +: 32];
    endfunction

    task automatic fill(input logic [25:0] t, input logic [63:0] salt);
        tag_i           = t;
        active_set_i    = 1'b1;
        ic_repl_grant_i = 1'b1;
        for (int b = 0; b < 8; b++) begin
            rep_word_i = beats[b] ^ salt;
            #1;
            check("fill_pending_miss", {31'd0, cache_set_miss_o}, 32'd1);
            step();
        end
        ic_repl_grant_i = 1'b0;
        rep_word_i      = '0;
        #1;
    endtask

    initial begin
        beats[0] = {32'hFEDCBA98, 32'h00AA00AA};
        beats[1] = {32'h99999999, 32'h12345678};
        beats[2] = {32'h77777777, 32'h88888888};
        beats[3] = 64'h3333_4444_5555_6666;
        beats[4] = 64'hA1A2_A3A4_B1B2_B3B4;
        beats[5] = 64'hC0DE_0001_C0DE_0002;
        beats[6] = 64'h0BAD_F00D_CAFE_BABE;
        beats[7] = 64'h1357_9BDF_2468_ACE0;
        tags[0] = 26'd500; tags[1] = 26'd600;
        tags[2] = 26'd700; tags[3] = 26'd800;

        reset_i         = 1'b0;
        active_set_i    = 1'b0;
        ic_repl_grant_i = 1'b0;
        block_i         = '0;
        tag_i           = '0;
        rep_word_i      = '0;
        repeat (3) step();
        check("reset_miss", {31'd0, cache_set_miss_o}, 32'd1);
        check("reset_data", data_o, 32'd0);
        check_lru("reset_lru", 3, 2, 1, 0);

        reset_i = 1'b1;
        repeat (10) step();
        active_set_i = 1'b1;
        tag_i        = 26'd500;
        #1;
        check("cold_miss", {31'd0, cache_set_miss_o}, 32'd1);
        check("cold_data", data_o, 32'd0);

        for (int k = 0; k < 4; k++) begin
            fill(tags[k], 64'd0);
            block_i = '0;
            #1;
            check("fill_hit", {31'd0, cache_set_miss_o}, 32'd0);
            check("fill_word0", data_o, 32'h00AA00AA);
        end
        check_lru("lru_after_fills", 3, 2, 1, 0);

        tags[0] = 26'd800; tags[1] = 26'd700;
        tags[2] = 26'd600; tags[3] = 26'd500;
        blks[0] = 6'd4;  blks[1] = 6'd8;
        blks[2] = 6'd12; blks[3] = 6'd16;
        hexp[0] = 32'hFEDCBA98; hexp[1] = 32'h12345678;
        hexp[2] = 32'h99999999; hexp[3] = 32'h88888888;
        for (int k = 0; k < 4; k++) begin
            tag_i   = tags[k];
            block_i = blks[k];
            #1;
            check("hit_miss", {31'd0, cache_set_miss_o}, 32'd0);
            check("hit_data", data_o, hexp[k]);
            step();
        end
        check_lru("lru_after_hits", 0, 1, 2, 3);
        repeat (3) step();
        check_lru("lru_mru_rehit", 0, 1, 2, 3);

        active_set_i    = 1'b0;
        ic_repl_grant_i = 1'b1;
        rep_word_i      = 64'hFFFF_0000_FFFF_0000;
        for (int i = 0; i < 64; i++) begin
            tag_i = 26'(500 + 100 * (i % 6));
            #1;
            check("inactive_miss", {31'd0, cache_set_miss_o}, 32'd1);
            check("inactive_data", data_o, 32'd0);
            step();
        end
        check_lru("lru_inactive", 0, 1, 2, 3);

        active_set_i    = 1'b1;
        tag_i           = 26'd1000;
        ic_repl_grant_i = 1'b1;
        repeat (3) step();
        ic_repl_grant_i = 1'b0;
        step();
        check("partial_miss", {31'd0, cache_set_miss_o}, 32'd1);
        check_lru("lru_partial", 0, 1, 2, 3);

        fill(26'd1000, SALT);
        block_i = 6'd20;
        #1;
        check("new_hit", {31'd0, cache_set_miss_o}, 32'd0);
        check("new_data", data_o, word_of(SALT, 6'd20));
        check_lru("lru_replace", 1, 2, 3, 0);
        tag_i = 26'd800;
        #1;
        check("evicted_miss", {31'd0, cache_set_miss_o}, 32'd1);

        tag_i           = 26'd600;
        block_i         = 6'd14;
        ic_repl_grant_i = 1'b1;
        #1;
        check("hit600_data", data_o, 32'h99999999);
        step();
        ic_repl_grant_i = 1'b0;
        check_lru("lru_hit600", 2, 0, 3, 1);
        check("hit600_keep", data_o, 32'h99999999);

        tag_i           = 26'd1100;
        ic_repl_grant_i = 1'b1;
        rep_word_i      = 64'h5555_AAAA_5555_AAAA;
        repeat (4) step();
        reset_i = 1'b0;
        #1;
        check("rst_mid_miss", {31'd0, cache_set_miss_o}, 32'd1);
        check_lru("rst_mid_lru", 3, 2, 1, 0);
        ic_repl_grant_i = 1'b0;
        step();
        reset_i = 1'b1;
        step();
        check("abort_miss", {31'd0, cache_set_miss_o}, 32'd1);
        check("abort_data", data_o, 32'd0);
        tag_i = 26'd600;
        #1;
        check("abort_old_miss", {31'd0, cache_set_miss_o}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_cache_set_multi.md
INSTR_CACHE_SET_MULTI -- requirements
Module: instr_cache_set_multi

Interface
REQ-001 Parameter B, default 64: block size in bytes; multiple of 8.
REQ-002 Parameter num_tag_bits, default 26: tag width.
REQ-003 Parameter E, default 4: ways per set; power of two.
REQ-004 clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 reset_i  input  1  reset; asynchronous, active-low.
REQ-006 active_set_i  input  1  this set is addressed by the current fetch.
REQ-007 ic_repl_grant_i  input  1  fill grant; rep_word_i carries valid fill data while high.
REQ-008 block_i  input  $clog2(B)  byte offset within the block.
REQ-009 tag_i  input  num_tag_bits  lookup/fill tag.
REQ-010 rep_word_i  input  64  one 64-bit fill beat.
REQ-011 data_o  output  32  instruction word read on hit.
REQ-012 cache_set_miss_o  output  1  high when no valid way matches or set is inactive.

Function
REQ-013 Per way, hold: valid bit, tag (num_tag_bits), data (B*8 bits), age lru_bits[way] ($clog2(E) bits); 0 means most recent, E-1 means least recent.
REQ-014 Hit is combinational: active_set_i high AND some valid way has tag equal to tag_i.
REQ-015 cache_set_miss_o SHALL be the inverse of hit; it SHALL be 1 whenever active_set_i is low.
REQ-016 On hit, data_o SHALL equal the hit way's data bits [block_i*8 +: 32], with block_i[1:0] forced to 0; on miss data_o SHALL be 0.
REQ-017 The victim way SHALL be the way whose lru_bits equals E-1.
REQ-018 Fill: on each rising edge with active_set_i=1, miss, and ic_repl_grant_i=1, write rep_word_i into victim data bits [cnt*64 +: 64] and increment the beat counter cnt (width $clog2(B/8)).
REQ-019 On the edge that writes beat B/8-1, also set the victim valid, store tag_i, clear cnt to 0 and apply the age update (REQ-021) to the victim; hit SHALL be visible right after that edge.
REQ-020 cnt SHALL clear to 0 on any edge where ic_repl_grant_i is low, active_set_i is low, or a hit occurs; a partial fill leaves valid and tag unchanged.
REQ-021 Age update on edge with hit (or fill completion) on way w of old age a: lru_bits[w] becomes 0; every way with age < a increments; others keep their age.
REQ-022 Repeated hits on the age-0 way SHALL leave all ages unchanged.
REQ-023 With active_set_i low, no state SHALL change, regardless of ic_repl_grant_i or tag_i.
REQ-024 Hit has priority over fill; ic_repl_grant_i SHALL be ignored while hitting.

Reset
REQ-025 While reset_i is low: all valid bits cleared, cnt cleared, lru_bits[i] = E-1-i (way 0 least recent), so empty ways fill in order 0,1,…,E-1.
REQ-026 Tags and data need no reset; data_o=0 and cache_set_miss_o=1 SHALL hold during and after reset until a fill completes.
REQ-027 Reset asserted mid-fill SHALL abort the fill with no way becoming valid.

Structure
REQ-028 Default values of B, num_tag_bits and E belong in the shared cache parameter package.
REQ-029 The age update and victim selection logic SHALL reside in one sub-module, cache_lru_ctrl, instantiated per set; tag/data/valid storage stays in this module.
REQ-030 The internal age array SHALL be named lru_bits, indexed by way, so benches can probe it hierarchically.

Verification
REQ-031 After reset, idle 10 cycles, then active_set_i=1, tag_i=500 -> cache_set_miss_o=1, data_o=0.
REQ-032 Four fills (tags 500,600,700,800), 8 beats each of a 512-bit block with word0=32'h00AA00AA -> after each 8th beat, hit with data_o=32'h00AA00AA at block_i=0; lru_bits = {3,2,1,0} for ways 0..3.
REQ-033 Hits on tags 800,700,600,500 with block_i=4,8,12,16 -> data_o = 32'hFEDCBA98, 32'h12345678, 32'h99999999, 32'h88888888; final lru_bits = {0,1,2,3}.
REQ-034 active_set_i=0, ic_repl_grant_i=1 for 64 cycles with tag changes -> miss=1 every cycle; lru_bits unchanged.
REQ-035 Tag 1000 miss, 8-beat fill -> way 3 replaced, lru_bits = {1,2,3,0}, data_o from the new block at current block_i.
REQ-036 Then hit tag 600 (way 1, age 2) -> lru_bits = {2,0,3,1}.
